neuron_parameter_bank: RTL and testbench

NEURON_PARAMETER_BANK -- requirements
Module: neuron_parameter_bank

---
 rtl/neuron_pkg.sv | 35 +++
 rtl/neuron_param_slot.sv | 75 +++++++
 rtl/neuron_parameter_bank.sv | 143 ++++++++++++++
 tb/tb_neuron_parameter_bank.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/neuron_pkg.sv
// Shared encodings for the neuron parameter bank: bus word selects, lane positions
// inside a bus word and the field order used for the packed core fetch.
package neuron_pkg;

    typedef enum logic [1:0] {
        WORD_RESET  = 2'd0,
        WORD_WEIGHT = 2'd1,
        WORD_STATE  = 2'd2,
        WORD_RSVD   = 2'd3
    } word_sel_e;

    // Field slots in the packed core vector; slot 0 is the least significant.
    localparam int NUM_FIELDS    = 10;
    localparam int FLD_NEG_RESET = 0;
    localparam int FLD_POS_RESET = 1;
    localparam int FLD_W4        = 2;
    localparam int FLD_W3        = 3;
    localparam int FLD_W2        = 4;
    localparam int FLD_W1        = 5;
    localparam int FLD_LEAK      = 6;
    localparam int FLD_NEG_THR   = 7;
    localparam int FLD_POS_THR   = 8;
    localparam int FLD_VOLTAGE   = 9;

    // Lane positions inside a 4-field bus word; lane 0 is the most significant field.
    localparam int LANE0 = 3;
    localparam int LANE1 = 2;
    localparam int LANE2 = 1;
    localparam int LANE3 = 0;

    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/neuron_param_slot.sv
// Parameter storage for a single neuron, including the voltage write priority
// between the clear strobe, bus writes and the external write-back.
module neuron_param_slot
    import neuron_pkg::*;
#(
    parameter int PARAM_W = 8
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic                             bus_we_i,
    input  logic [1:0]                       word_sel_i,
    input  logic [4*PARAM_W-1:0]             d_i,
    input  logic                             ext_we_i,
    input  logic [PARAM_W-1:0]               ext_v_i,
    input  logic                             vclr_i,
    output logic [NUM_FIELDS*PARAM_W-1:0]    fields_o
);

    logic [PARAM_W-1:0] fld_q [NUM_FIELDS];
    logic [PARAM_W-1:0] fld_d [NUM_FIELDS];

    function automatic logic [PARAM_W-1:0] lane(input logic [4*PARAM_W-1:0] w, input int k);
        return w[k*PARAM_W +: PARAM_W];
    endfunction

    always_comb begin
        fld_d = fld_q;
        if (bus_we_i) begin
            case (word_sel_e'(word_sel_i))
                WORD_RESET: begin
                    fld_d[FLD_POS_RESET] = lane(d_i, LANE0);
                    fld_d[FLD_NEG_RESET] = lane(d_i, LANE1);
                end
                WORD_WEIGHT: begin
                    fld_d[FLD_W1] = lane(d_i, LANE0);
                    fld_d[FLD_W2] = lane(d_i, LANE1);
                    fld_d[FLD_W3] = lane(d_i, LANE2);
                    fld_d[FLD_W4] = lane(d_i, LANE3);
                end
                WORD_STATE: begin
                    fld_d[FLD_POS_THR] = lane(d_i, LANE1);
                    fld_d[FLD_NEG_THR] = lane(d_i, LANE2);
                    fld_d[FLD_LEAK]    = lane(d_i, LANE3);
                end
                default: ;
            endcase
        end
        // Voltage has three writers; the lower-priority ones are dropped silently.
        if (vclr_i) begin
            fld_d[FLD_VOLTAGE] = '0;
        end else if (bus_we_i && (word_sel_i == WORD_STATE)) begin
            fld_d[FLD_VOLTAGE] = lane(d_i, LANE0);
        end else if (ext_we_i) begin
            fld_d[FLD_VOLTAGE] = ext_v_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < NUM_FIELDS; k++) begin
                fld_q[k] <= '0;
            end
        end else begin
            fld_q <= fld_d;
        end
    end

    always_comb begin
        fields_o = '0;
        for (int k = 0; k < NUM_FIELDS; k++) begin
            fields_o[k*PARAM_W +: PARAM_W] = fld_q[k];
        end
    end

endmodule

// File: rtl/neuron_parameter_bank.sv
// Bank of per-neuron parameter sets with a word-addressed bus port, an external
// voltage write-back port and a single-cycle core fetch port, all running concurrently.
module neuron_parameter_bank
    import neuron_pkg::*;
#(
    parameter  int NUM_NEURONS = 16,
    parameter  int PARAM_W     = 8,
    localparam int DATA_W      = 4*PARAM_W,
    localparam int IDX_W       = idx_width(NUM_NEURONS),
    localparam int ADDR_W      = IDX_W + 2
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          en_i,
    input  logic                          we_i,
    input  logic [ADDR_W-1:0]             addr_i,
    input  logic [DATA_W-1:0]             d_i,
    output logic [DATA_W-1:0]             q_o,
    output logic                          ack_o,
    output logic                          err_o,
    input  logic                          ext_we_i,
    input  logic [IDX_W-1:0]              ext_idx_i,
    input  logic [PARAM_W-1:0]            ext_v_i,
    input  logic                          vclr_i,
    input  logic                          core_rd_i,
    input  logic [IDX_W-1:0]              core_idx_i,
    output logic                          core_vld_o,
    output logic [NUM_FIELDS*PARAM_W-1:0] core_params_o
);

    localparam int CP_W = NUM_FIELDS*PARAM_W;
    localparam logic [IDX_W:0] NUM_LIMIT = NUM_NEURONS[IDX_W:0];

    logic [IDX_W-1:0]  bus_idx;
    logic [1:0]        bus_word;
    logic              bus_in_range;
    logic              ext_in_range;
    logic [CP_W-1:0]   slot_fields [NUM_NEURONS];
    logic [CP_W-1:0]   bus_fields;
    logic [CP_W-1:0]   core_fields;
    logic [DATA_W-1:0] rd_word;

    logic [DATA_W-1:0] q_q, q_d;
    logic              ack_q, ack_d;
    logic              err_q, err_d;
    logic              core_vld_q, core_vld_d;
    logic [CP_W-1:0]   core_params_q, core_params_d;

    assign bus_idx      = addr_i[ADDR_W-1:2];
    assign bus_word     = addr_i[1:0];
    assign bus_in_range = ({1'b0, bus_idx} < NUM_LIMIT);
    assign ext_in_range = ({1'b0, ext_idx_i} < NUM_LIMIT);

    for (genvar g = 0; g < NUM_NEURONS; g++) begin : g_slot
        neuron_param_slot #(
            .PARAM_W (PARAM_W)
        ) u_slot (
            .clk_i      (clk_i),
            .rst_ni     (rst_ni),
            .bus_we_i   (en_i && we_i && bus_in_range && (bus_idx == IDX_W'(g))),
            .word_sel_i (bus_word),
            .d_i        (d_i),
            .ext_we_i   (ext_we_i && ext_in_range && (ext_idx_i == IDX_W'(g))),
            .ext_v_i    (ext_v_i),
            .vclr_i     (vclr_i),
            .fields_o   (slot_fields[g])
        );
    end

    // Indices with no slot match nothing, so an out-of-range fetch yields zeros.
    always_comb begin
        bus_fields  = '0;
        core_fields = '0;
        for (int i = 0; i < NUM_NEURONS; i++) begin
            if (bus_idx == IDX_W'(i)) begin
                bus_fields = slot_fields[i];
            end
            if (core_idx_i == IDX_W'(i)) begin
                core_fields = slot_fields[i];
            end
        end
    end

    always_comb begin
        rd_word = '0;
        case (word_sel_e'(bus_word))
            WORD_RESET: begin
                rd_word[LANE0*PARAM_W +: PARAM_W] = bus_fields[FLD_POS_RESET*PARAM_W +: PARAM_W];
                rd_word[LANE1*PARAM_W +: PARAM_W] = bus_fields[FLD_NEG_RESET*PARAM_W +: PARAM_W];
            end
            WORD_WEIGHT: begin
                rd_word[LANE0*PARAM_W +: PARAM_W] = bus_fields[FLD_W1*PARAM_W +: PARAM_W];
                rd_word[LANE1*PARAM_W +: PARAM_W] = bus_fields[FLD_W2*PARAM_W +: PARAM_W];
                rd_word[LANE2*PARAM_W +: PARAM_W] = bus_fields[FLD_W3*PARAM_W +: PARAM_W];
                rd_word[LANE3*PARAM_W +: PARAM_W] = bus_fields[FLD_W4*PARAM_W +: PARAM_W];
            end
            WORD_STATE: begin
                rd_word[LANE0*PARAM_W +: PARAM_W] = bus_fields[FLD_VOLTAGE*PARAM_W +: PARAM_W];
                rd_word[LANE1*PARAM_W +: PARAM_W] = bus_fields[FLD_POS_THR*PARAM_W +: PARAM_W];
                rd_word[LANE2*PARAM_W +: PARAM_W] = bus_fields[FLD_NEG_THR*PARAM_W +: PARAM_W];
                rd_word[LANE3*PARAM_W +: PARAM_W] = bus_fields[FLD_LEAK*PARAM_W +: PARAM_W];
            end
            default: ;
        endcase
    end

    // Read data is captured from the pre-edge storage and held across writes.
    always_comb begin
        ack_d         = en_i && bus_in_range;
        err_d         = en_i && !bus_in_range;
        q_d           = q_q;
        if (en_i && !bus_in_range) begin
            q_d = '0;
        end else if (en_i && !we_i) begin
            q_d = rd_word;
        end
        core_vld_d    = core_rd_i;
        core_params_d = core_rd_i ? core_fields : core_params_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q_q           <= '0;
            ack_q         <= 1'b0;
            err_q         <= 1'b0;
            core_vld_q    <= 1'b0;
            core_params_q <= '0;
        end else begin
            q_q           <= q_d;
            ack_q         <= ack_d;
            err_q         <= err_d;
            core_vld_q    <= core_vld_d;
            core_params_q <= core_params_d;
        end
    end

    assign q_o           = q_q;
    assign ack_o         = ack_q;
    assign err_o         = err_q;
    assign core_vld_o    = core_vld_q;
    assign core_params_o = core_params_q;

endmodule

// File: tb/tb_neuron_parameter_bank.sv
// Scoreboard bench for neuron_parameter_bank: a word-level reference model predicts
// every bus and core response, and a monitor matches them against the DUT outputs.
module tb_neuron_parameter_bank;

    localparam int NUM    = 10;
    localparam int PW     = 8;
    localparam int DW     = 32;
    localparam int IW     = 4;
    localparam int AW     = 6;
    localparam int CW     = 80;

    logic          clk = 1'b0;
    logic          rst_ni = 1'b0;
    logic          en_i = 1'b0;
    logic          we_i = 1'b0;
    logic [AW-1:0] addr_i = '0;
    logic [DW-1:0] d_i = '0;
    logic [DW-1:0] q_o;
    logic          ack_o;
    logic          err_o;
    logic          ext_we_i = 1'b0;
    logic [IW-1:0] ext_idx_i = '0;
    logic [PW-1:0] ext_v_i = '0;
    logic          vclr_i = 1'b0;
    logic          core_rd_i = 1'b0;
    logic [IW-1:0] core_idx_i = '0;
    logic          core_vld_o;
    logic [CW-1:0] core_params_o;

    neuron_parameter_bank #(
        .NUM_NEURONS (NUM),
        .PARAM_W     (PW)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_ni),
        .en_i          (en_i),
        .we_i          (we_i),
        .addr_i        (addr_i),
        .d_i           (d_i),
        .q_o           (q_o),
        .ack_o         (ack_o),
        .err_o         (err_o),
        .ext_we_i      (ext_we_i),
        .ext_idx_i     (ext_idx_i),
        .ext_v_i       (ext_v_i),
        .vclr_i        (vclr_i),
        .core_rd_i     (core_rd_i),
        .core_idx_i    (core_idx_i),
        .core_vld_o    (core_vld_o),
        .core_params_o (core_params_o)
    );

    always #5 clk = ~clk;

    typedef struct {int due; bit is_err; logic [DW-1:0] q;} bus_exp_t;
    typedef struct {int due; logic [CW-1:0] p;} core_exp_t;

    bus_exp_t  bus_q[$];
    core_exp_t core_q[$];
    int        checks = 0;
    int        errors = 0;
    int        cyc = 0;

    // Reference model holds whole bus words: word0 keeps only its upper half.
    logic [15:0]   m_w0 [NUM];
    logic [DW-1:0] m_w1 [NUM];
    logic [DW-1:0] m_w2 [NUM];
    logic [DW-1:0] m_q;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] modelWord(input int idx, input int w);
        case (w)
            0:       return {m_w0[idx], 16'h0000};
            1:       return m_w1[idx];
            2:       return m_w2[idx];
            default: return '0;
        endcase
    endfunction

    task automatic clearModel();
        for (int n = 0; n < NUM; n++) begin
            m_w0[n] = '0;
            m_w1[n] = '0;
            m_w2[n] = '0;
        end
        m_q = '0;
    endtask

    task automatic applyStimulus(input bit en, input bit we, input int idx, input int word,
                                 input logic [DW-1:0] d, input bit ext_we, input int ext_idx,
                                 input logic [PW-1:0] ext_v, input bit vclr,
                                 input bit core_rd, input int core_idx);
        logic [AW-1:0] a;
        logic [IW-1:0] ei;
        logic [IW-1:0] ci;
        logic [7:0]    v;
        bus_exp_t      be;
        core_exp_t     ce;
        @(negedge clk);
        a = {idx[IW-1:0], word[1:0]};
        ei = ext_idx[IW-1:0];
        ci = core_idx[IW-1:0];
        en_i = en; we_i = we; addr_i = a; d_i = d;
        ext_we_i = ext_we; ext_idx_i = ei; ext_v_i = ext_v;
        vclr_i = vclr; core_rd_i = core_rd; core_idx_i = ci;
        if (en) begin
            be.due = cyc + 1;
            if (idx >= NUM) begin
                m_q = '0;
                be.is_err = 1'b1;
            end else begin
                if (!we) m_q = modelWord(idx, word);
                be.is_err = 1'b0;
            end
            be.q = m_q;
            bus_q.push_back(be);
        end
        if (core_rd) begin
            ce.due = cyc + 1;
            ce.p = (core_idx < NUM) ? {m_w2[core_idx], m_w1[core_idx], m_w0[core_idx]} : '0;
            core_q.push_back(ce);
        end
        for (int n = 0; n < NUM; n++) begin
            v = m_w2[n][31:24];
            if (en && we && idx == n) begin
                if (word == 0) m_w0[n] = d[31:16];
                if (word == 1) m_w1[n] = d;
                if (word == 2) m_w2[n][23:0] = d[23:0];
            end
            if (vclr) v = 8'h00;
            else if (en && we && idx == n && word == 2) v = d[31:24];
            else if (ext_we && ext_idx == n) v = ext_v;
            m_w2[n][31:24] = v;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(0, 0, 0, 0, '0, 0, 0, '0, 0, 0, 0);
    endtask

    task automatic busWrite(input int idx, input int word, input logic [DW-1:0] d);
        applyStimulus(1, 1, idx, word, d, 0, 0, '0, 0, 0, 0);
    endtask

    task automatic busRead(input int idx, input int word);
        applyStimulus(1, 0, idx, word, '0, 0, 0, '0, 0, 0, 0);
    endtask

    // Every expected response is due exactly one cycle after its request.
    always @(posedge clk) begin
        bus_exp_t  be;
        core_exp_t ce;
        #1;
        if (rst_ni) begin
            while (bus_q.size() > 0 && bus_q[0].due < cyc) begin
                be = bus_q.pop_front();
                checkOutput("bus_missing_response", {79'h0, ack_o | err_o}, 80'h1);
            end
            if (bus_q.size() > 0 && bus_q[0].due == cyc) begin
                be = bus_q.pop_front();
                checkOutput("bus_ack", {79'h0, ack_o}, {79'h0, !be.is_err});
                checkOutput("bus_err", {79'h0, err_o}, {79'h0, be.is_err});
                checkOutput("bus_q", {48'h0, q_o}, {48'h0, be.q});
            end else if (ack_o || err_o) begin
                checkOutput("bus_stray_response", {78'h0, ack_o, err_o}, 80'h0);
            end
            while (core_q.size() > 0 && core_q[0].due < cyc) begin
                ce = core_q.pop_front();
                checkOutput("core_missing_vld", {79'h0, core_vld_o}, 80'h1);
            end
            if (core_q.size() > 0 && core_q[0].due == cyc) begin
                ce = core_q.pop_front();
                checkOutput("core_vld", {79'h0, core_vld_o}, 80'h1);
                checkOutput("core_params", core_params_o, ce.p);
            end else if (core_vld_o) begin
                checkOutput("core_stray_vld", {79'h0, core_vld_o}, 80'h0);
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        clearModel();
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_q", {48'h0, q_o}, 80'h0);
        checkOutput("reset_flags", {77'h0, ack_o, err_o, core_vld_o}, 80'h0);
        checkOutput("reset_core_params", core_params_o, 80'h0);
        @(negedge clk);
        rst_ni = 1'b1;
        idle(2);

        // Basic write/read of word2 on neuron 5.
        busWrite(5, 2, 32'h10203040);
        busRead(5, 2);
        @(posedge clk); #1;
        checkOutput("word2_readback", {48'h0, q_o}, {48'h0, 32'h10203040});

        // Voltage priority: bus write beats ext write-back, clear beats both.
        applyStimulus(1, 1, 5, 2, 32'hAA000000, 1, 5, 8'h55, 0, 0, 0);
        busRead(5, 2);
        @(posedge clk); #1;
        checkOutput("bus_beats_ext", {48'h0, q_o}, {48'h0, 32'hAA000000});
        applyStimulus(1, 1, 5, 2, 32'hAA000000, 1, 5, 8'h55, 1, 0, 0);
        busRead(5, 2);
        @(posedge clk); #1;
        checkOutput("vclr_beats_bus", {48'h0, q_o}, 80'h0);
        applyStimulus(0, 0, 0, 0, '0, 1, 5, 8'h77, 0, 0, 0);
        busRead(5, 2);
        @(posedge clk); #1;
        checkOutput("ext_writeback", {48'h0, q_o}, {48'h0, 32'h77000000});

        // Out-of-range index, word0 masking and reserved word3.
        busWrite(12, 1, 32'hFFFFFFFF);
        @(posedge clk); #1;
        checkOutput("oor_err", {78'h0, err_o, ack_o}, 80'h2);
        busRead(12, 2);
        busWrite(1, 0, 32'hDEADBEEF);
        busRead(1, 0);
        @(posedge clk); #1;
        checkOutput("word0_masked", {48'h0, q_o}, {48'h0, 32'hDEAD0000});
        busWrite(1, 3, 32'h12345678);
        busRead(1, 3);
        @(posedge clk); #1;
        checkOutput("word3_zero", {48'h0, q_o}, 80'h0);

        // Core fetch on the same edge as a weight write returns the old weights.
        busWrite(3, 1, 32'hA1B2C3D4);
        applyStimulus(1, 1, 3, 1, 32'h11223344, 0, 0, '0, 0, 1, 3);
        @(posedge clk); #1;
        checkOutput("core_old_weights", {48'h0, core_params_o[47:16]}, {48'h0, 32'hA1B2C3D4});
        applyStimulus(0, 0, 0, 0, '0, 0, 0, '0, 0, 1, 3);
        @(posedge clk); #1;
        checkOutput("core_new_weights", {48'h0, core_params_o[47:16]}, {48'h0, 32'h11223344});
        applyStimulus(0, 0, 0, 0, '0, 0, 0, '0, 0, 1, 13);
        @(posedge clk); #1;
        checkOutput("core_oor_zero", core_params_o, 80'h0);

        // Randomised concurrent traffic on all three ports.
        for (int i = 0; i < 600; i++) begin
            applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                          $urandom_range(0, 15), $urandom_range(0, 3), $urandom,
                          $urandom_range(0, 2) == 0, $urandom_range(0, 15), 8'($urandom),
                          $urandom_range(0, 15) == 0, $urandom_range(0, 1) == 1,
                          $urandom_range(0, 15));
        end
        idle(2);

        // Fill every neuron, then pull reset in the middle of a read.
        for (int n = 0; n < NUM; n++) begin
            for (int w = 0; w < 3; w++) busWrite(n, w, $urandom | 32'h01010101);
        end
        busRead(2, 1);
        #2;
        rst_ni = 1'b0;
        en_i = 1'b0; we_i = 1'b0; core_rd_i = 1'b0; ext_we_i = 1'b0; vclr_i = 1'b0;
        bus_q.delete();
        core_q.delete();
        clearModel();
        #1;
        checkOutput("async_reset_q", {48'h0, q_o}, 80'h0);
        @(posedge clk); #1;
        checkOutput("reset_mid_read_flags", {77'h0, ack_o, err_o, core_vld_o}, 80'h0);
        checkOutput("reset_mid_read_core", core_params_o, 80'h0);
        @(negedge clk);
        rst_ni = 1'b1;
        idle(2);
        for (int n = 0; n < NUM; n++) begin
            for (int w = 0; w < 4; w++) busRead(n, w);
            applyStimulus(0, 0, 0, 0, '0, 0, 0, '0, 0, 1, n);
        end
        idle(3);
        checkOutput("bus_queue_drained", 80'(bus_q.size()), 80'h0);
        checkOutput("core_queue_drained", 80'(core_q.size()), 80'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
